bool_share_split: RTL and testbench

Serial Boolean share generator, the masking-side counterpart of the full-XOR recombiner. Accepts one unmasked K_WIDTH word, consumes N_SHARES-1 fresh random words (one per cycle while available), and emits N_SHARES Boolean shares whose XOR equals the input. It sits at the entry of the masked datapath and feeds the share-domain blocks (B2A, refresh, recombine), with a valid/ready handshake on the output side.

---
 rtl/bool_share_split.sv | 104 ++++++++++
 tb/tb_bool_share_split.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bool_share_split.sv
// bool_share_split
// Serial Boolean share generator at the entry of the masked datapath.
// It takes one unmasked word and turns it into N_SHARES Boolean shares whose
// XOR equals that word. Shares 0..N-2 are fresh random words taken one per
// cycle. The last share is the input XORed with all of those random words.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset (overrides ena)
//   ena           global enable; all state frozen while low
//   dvld, i_x     unmasked input word, accepted only while irdy=1
//   irdy          idle, ready for a new word
//   rnd, rnd_vld  fresh random word, consumed one per cycle in SPLIT
//   o_x, ovld     packed shares (share i at [i*K_WIDTH +: K_WIDTH]);
//                 o_x is zero unless ovld=1
//   ordy          downstream accepts the shares
module bool_share_split #(
   parameter int K_WIDTH   = 32,
   parameter int N_SHARES  = 8,
   parameter int MASKWIDTH = K_WIDTH * N_SHARES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 dvld,
   input  logic [K_WIDTH-1:0]   i_x,
   output logic                 irdy,
   input  logic [K_WIDTH-1:0]   rnd,
   input  logic                 rnd_vld,
   output logic [MASKWIDTH-1:0] o_x,
   output logic                 ovld,
   input  logic                 ordy
);

   localparam int CW = (N_SHARES > 1) ? $clog2(N_SHARES) : 1;

   typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

   state_t                            state, state_nx;
   logic [K_WIDTH-1:0]                acc;
   logic [CW-1:0]                     cnt;
   logic [N_SHARES-1:0][K_WIDTH-1:0]  shares;
   logic                              last;

   // The word being consumed now completes the set of random shares.
   assign last = (cnt == CW'(N_SHARES - 2));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (dvld) state_nx = (N_SHARES == 1) ? DONE : SPLIT;
         SPLIT: if (rnd_vld && last) state_nx = DONE;
         DONE:  if (ordy) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         cnt    <= '0;
         shares <= '0;
      end else if (ena) begin
         state <= state_nx;
         case (state)
            IDLE: if (dvld) begin
               cnt <= '0;
               if (N_SHARES == 1) begin
                  // A single share is the word itself. The accumulator
                  // never holds plaintext in this case.
                  shares[0] <= i_x;
                  acc       <= '0;
               end else begin
                  acc <= i_x;
               end
            end
            SPLIT: if (rnd_vld) begin
               for (int i = 0; i < N_SHARES; i++)
                  if (cnt == CW'(i)) shares[i] <= rnd;
               cnt <= cnt + 1'b1;
               if (last) begin
                  // Form the closing share and clear the masked
                  // remainder right away.
                  shares[N_SHARES-1] <= acc ^ rnd;
                  acc                <= '0;
               end else begin
                  acc <= acc ^ rnd;
               end
            end
            DONE: if (ordy) begin
               shares <= '0;
               cnt    <= '0;
            end
            default: ;
         endcase
      end
   end

   assign irdy = (state == IDLE);
   assign ovld = (state == DONE);
   // Only complete share sets ever leave the block.
   assign o_x  = ovld ? shares : '0;

endmodule

// File: tb/tb_bool_share_split.sv
module tb_bool_share_split;

   logic         clk = 1'b0;
   logic         rst, ena;
   logic         dvld, rnd_vld, ordy;
   logic [31:0]  i_x, rnd;
   logic         irdy, ovld;
   logic [255:0] o_x;

   logic         dvld1, rnd_vld1, ordy1;
   logic [31:0]  i_x1;
   logic         irdy1, ovld1;
   logic [31:0]  o_x1;

   int cmp_cnt = 0;
   int err_cnt = 0;

   logic [255:0] exp_a, exp_b;

   always #5 clk = ~clk;

   bool_share_split #(.K_WIDTH(32), .N_SHARES(8)) dut (
      .clk(clk), .rst(rst), .ena(ena), .dvld(dvld), .i_x(i_x), .irdy(irdy),
      .rnd(rnd), .rnd_vld(rnd_vld), .o_x(o_x), .ovld(ovld), .ordy(ordy));

   bool_share_split #(.K_WIDTH(32), .N_SHARES(1)) dut1 (
      .clk(clk), .rst(rst), .ena(ena), .dvld(dvld1), .i_x(i_x1), .irdy(irdy1),
      .rnd(rnd), .rnd_vld(rnd_vld1), .o_x(o_x1), .ovld(ovld1), .ordy(ordy1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      cmp_cnt++;
      assert (obs === expv) else begin
         err_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] xor_all(input logic [255:0] v);
      logic [31:0] r = '0;
      for (int i = 0; i < 8; i++) r ^= v[i*32 +: 32];
      return r;
   endfunction

   initial begin
      // expected share sets built from hand-chosen constants
      for (int i = 0; i < 7; i++) exp_a[i*32 +: 32] = 32'(i + 1);
      exp_a[7*32 +: 32] = 32'hDEADBEEF;   // 1^2^..^7 = 0
      for (int i = 0; i < 7; i++) exp_b[i*32 +: 32] = 32'hFFFFFFFF;
      exp_b[7*32 +: 32] = 32'h5A5A5A5A;

      rst = 1; ena = 1; dvld = 0; rnd_vld = 0; ordy = 0; i_x = 0; rnd = 0;
      dvld1 = 0; rnd_vld1 = 0; ordy1 = 0; i_x1 = 0;
      #1;
      tick(); tick();
      rst = 0;
      check("rst_irdy", irdy, 1);
      check("rst_ovld", ovld, 0);
      check("rst_ox", o_x, 0);
      check("rst_irdy1", irdy1, 1);
      check("rst_ovld1", ovld1, 0);

      // job 1: continuous random words, ordy=1
      ordy = 1; dvld = 1; i_x = 32'hDEADBEEF;
      tick();
      dvld = 0;
      check("j1_busy", irdy, 0);
      for (int k = 1; k <= 7; k++) begin
         rnd = 32'(k); rnd_vld = 1;
         tick();
         check($sformatf("j1_ovld_%0d", k), ovld, (k == 7));
      end
      rnd_vld = 0;
      check("j1_ox", o_x, exp_a);
      tick();
      check("j1_ovld_drop", ovld, 0);
      check("j1_irdy_back", irdy, 1);
      check("j1_ox_zero", o_x, 0);

      // job 2: rnd_vld toggling, then back-pressure in DONE
      ordy = 0; dvld = 1; i_x = 32'hDEADBEEF;
      tick();
      dvld = 0;
      for (int k = 1; k <= 7; k++) begin
         rnd = 32'(k); rnd_vld = 1;
         tick();
         if (k < 7) begin
            check($sformatf("j2_ovld_v%0d", k), ovld, 0);
            rnd = 32'h99; rnd_vld = 0;
            tick();
            check($sformatf("j2_ovld_g%0d", k), ovld, 0);
            check($sformatf("j2_ox_g%0d", k), o_x, 0);
         end
      end
      rnd_vld = 0;
      check("j2_ovld", ovld, 1);
      check("j2_ox", o_x, exp_a);
      dvld = 1; i_x = 32'h12345678;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("bp_ovld_%0d", k), ovld, 1);
         check($sformatf("bp_ox_%0d", k), o_x, exp_a);
      end
      check("bp_xor", xor_all(o_x), 32'hDEADBEEF);
      dvld = 0; ordy = 1;
      tick();
      check("bp_irdy", irdy, 1);
      check("bp_ovld", ovld, 0);

      // job 3: reset after three words, then a fresh job
      ordy = 0; dvld = 1; i_x = 32'hDEADBEEF;
      tick();
      dvld = 0;
      for (int k = 1; k <= 3; k++) begin
         rnd = 32'(k); rnd_vld = 1;
         tick();
      end
      rnd_vld = 0; rst = 1;
      tick();
      rst = 0;
      check("mrst_irdy", irdy, 1);
      check("mrst_ovld", ovld, 0);
      check("mrst_ox", o_x, 0);
      dvld = 1; i_x = 32'hA5A5A5A5;
      tick();
      dvld = 0; rnd = 32'hFFFFFFFF; rnd_vld = 1;
      for (int k = 1; k <= 7; k++) tick();
      rnd_vld = 0;
      check("j3_ovld", ovld, 1);
      check("j3_ox", o_x, exp_b);
      ordy = 1;
      tick();
      check("j3_irdy", irdy, 1);

      // job 4: ena low for five cycles mid-SPLIT
      ordy = 0; dvld = 1; i_x = 32'hDEADBEEF;
      tick();
      dvld = 0;
      for (int k = 1; k <= 2; k++) begin
         rnd = 32'(k); rnd_vld = 1;
         tick();
      end
      ena = 0; rnd = 32'h99; rnd_vld = 1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("ena0_busy_%0d", k), {ovld, irdy}, 2'b00);
      end
      ena = 1;
      for (int k = 3; k <= 7; k++) begin
         rnd = 32'(k); rnd_vld = 1;
         tick();
         check($sformatf("j4_ovld_%0d", k), ovld, (k == 7));
      end
      rnd_vld = 0;
      check("j4_ox", o_x, exp_a);
      ena = 0; ordy = 1;
      tick();
      check("ena0_done_hold", ovld, 1);
      check("ena0_done_ox", o_x, exp_a);
      ena = 1;
      tick();
      check("j4_irdy", irdy, 1);
      ordy = 0;

      // single-share instance
      dvld1 = 1; i_x1 = 32'hCAFEF00D; rnd_vld1 = 1; rnd = 32'h0BADBEEF;
      tick();
      dvld1 = 0;
      check("n1_ovld", ovld1, 1);
      check("n1_ox", o_x1, 32'hCAFEF00D);
      tick();
      check("n1_hold", o_x1, 32'hCAFEF00D);
      ordy1 = 1;
      tick();
      check("n1_irdy", irdy1, 1);
      check("n1_ox_zero", o_x1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
